// File: rtl/alu_pkg.sv
// Shared ALU types: flag bundle layout, flag bit positions and opcodes.
package alu_pkg;

  typedef struct packed {
    logic o;
    logic c;
    logic z;
    logic n;
  } alu_flags_t;

  localparam int FLAG_O = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    INC = 3'd2,
    AND = 3'd3,
    OR  = 3'd4,
    XOR = 3'd5,
    NOT = 3'd6
  } alu_op_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; full/empty come from the occupancy count.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid_i,
  output logic          push_ready_o,
  input  logic [W-1:0]  push_data_i,
  output logic          pop_valid_o,
  input  logic          pop_ready_i,
  output logic [W-1:0]  pop_data_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign push_ready_o = ~rst & (count_q < FULL);
  assign pop_valid_o  = ~rst & (count_q != '0);
  assign push         = push_valid_i & push_ready_o;
  assign pop          = pop_valid_o & pop_ready_i;
  assign pop_data_o   = pop_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o      = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; stale slots are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/alu_result_buf.sv
// ALU result stage: buffers results for writeback and keeps the
// architectural flag register plus a sticky overflow bit.
module alu_result_buf
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_y,
  input  logic [3:0]       in_flags,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_flag_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       flags_q,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CW-1:0]    count
);

  localparam int W = 32 + 4 + TAG_W;

  logic [W-1:0] head;
  alu_flags_t   in_f;
  alu_flags_t   flg_q, flg_d;
  logic         sticky_q, sticky_d;
  logic         push, flag_push;

  sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (in_valid),
    .push_ready_o (in_ready),
    .push_data_i  ({in_y, in_flags, in_tag}),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_data_o   (head),
    .count_o      (count)
  );

  assign out_tag   = head[TAG_W-1:0];
  assign out_flags = head[TAG_W+3:TAG_W];
  assign out_y     = head[W-1:TAG_W+4];

  assign in_f      = alu_flags_t'(in_flags);
  assign push      = in_valid & in_ready;
  assign flag_push = push & in_flag_we;

  always_comb begin
    flg_d    = flag_push ? in_f : flg_q;
    sticky_d = sticky_q;
    // A new overflow outranks a same-cycle clear.
    if (flag_push && in_f.o) sticky_d = 1'b1;
    else if (clr_sticky)     sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flg_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      flg_q    <= flg_d;
      sticky_q <= sticky_d;
    end
  end

  assign flags_q    = flg_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_alu_result_buf.sv
// Bench for alu_result_buf: queue model checked every cycle plus
// hand-computed directed expectations.
module tb_alu_result_buf;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_y;
  logic [3:0]       in_flags;
  logic [TAG_W-1:0] in_tag;
  logic             in_flag_we;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       flags_q;
  logic             sticky_ovf;
  logic             clr_sticky;
  logic [CW-1:0]    count;

  alu_result_buf #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_y       (in_y),
    .in_flags   (in_flags),
    .in_tag     (in_tag),
    .in_flag_we (in_flag_we),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_flags  (out_flags),
    .out_tag    (out_tag),
    .flags_q    (flags_q),
    .sticky_ovf (sticky_ovf),
    .clr_sticky (clr_sticky),
    .count      (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0]      y;
    logic [3:0]       f;
    logic [TAG_W-1:0] t;
  } ent_t;

  ent_t     mq[$];
  logic [3:0] mflags;
  logic       msticky;

  initial begin
    mflags  = '0;
    msticky = 1'b0;
  end

  // Reference: an ordered list of accepted results, plus flag state.
  always @(posedge clk) begin
    bit acc, pp;
    if (rst) begin
      mq.delete();
      mflags  = '0;
      msticky = 1'b0;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      pp  = out_ready && (mq.size() > 0);
      if (acc && in_flag_we) mflags = in_flags;
      if (acc && in_flag_we && in_flags[3]) msticky = 1'b1;
      else if (clr_sticky)                  msticky = 1'b0;
      if (pp)  void'(mq.pop_front());
      if (acc) mq.push_back('{in_y, in_flags, in_tag});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = !rst && (mq.size() > 0);
      chk("m_in_ready", 64'(in_ready), 64'(!rst && (mq.size() < DEPTH)));
      chk("m_out_valid", 64'(out_valid), 64'(ev));
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_out_y", 64'(out_y), ev ? 64'(mq[0].y) : 64'd0);
      chk("m_out_flags", 64'(out_flags), ev ? 64'(mq[0].f) : 64'd0);
      chk("m_out_tag", 64'(out_tag), ev ? 64'(mq[0].t) : 64'd0);
      chk("m_flags_q", 64'(flags_q), 64'(mflags));
      chk("m_sticky", 64'(sticky_ovf), 64'(msticky));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit v, logic [31:0] y, logic [3:0] f,
                        logic [TAG_W-1:0] t, bit we);
    in_valid   = v;
    in_y       = y;
    in_flags   = f;
    in_tag     = t;
    in_flag_we = we;
  endtask

  initial begin
    rst        = 1'b1;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    set_in(1'b1, 32'h55, 4'hF, '0, 1'b1);

    // Reset held two edges with in_valid asserted
    step();
    chk_en = 1'b1;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_flags", 64'(flags_q), 64'd0);
    chk("rst_sticky", 64'(sticky_ovf), 64'd0);
    rst = 1'b0;
    set_in(1'b0, '0, '0, '0, 1'b0);
    step();
    chk("post_rst_count", 64'(count), 64'd0);

    // Fill to DEPTH, then an ignored fifth push
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'(i + 1), 4'h0, TAG_W'(i), 1'b0);
      step();
    end
    set_in(1'b1, 32'd5, 4'h0, 4'd4, 1'b0);
    step();
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    set_in(1'b0, '0, '0, '0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_y", 64'(out_y), 64'(i + 1));
      chk("drain_tag", 64'(out_tag), 64'(i));
      step();
    end
    chk("drained_valid", 64'(out_valid), 64'd0);
    chk("drained_y", 64'(out_y), 64'd0);

    // Steady push+pop at occupancy 2, wrapping the pointers
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 32'(10 + i), 4'h0, TAG_W'(i), 1'b0);
      step();
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      set_in(1'b1, 32'(11 + k), 4'h0, TAG_W'(k + 1), 1'b0);
      step();
      chk("stream_count", 64'(count), 64'd2);
      chk("stream_head", 64'(out_y), 64'(10 + k));
    end
    set_in(1'b0, '0, '0, '0, 1'b0);
    step();
    step();
    chk("stream_empty", 64'(count), 64'd0);

    // Flag register follows only flag-writing pushes
    out_ready = 1'b0;
    set_in(1'b1, 32'hA, 4'b0001, 4'd1, 1'b1);
    step();
    chk("flags_we1", 64'(flags_q), 64'h1);
    set_in(1'b1, 32'hB, 4'b1000, 4'd2, 1'b0);
    step();
    chk("flags_we0", 64'(flags_q), 64'h1);
    chk("flags_sticky0", 64'(sticky_ovf), 64'd0);
    set_in(1'b0, '0, '0, '0, 1'b0);
    chk("head_flags1", 64'(out_flags), 64'h1);
    out_ready = 1'b1;
    step();
    chk("head_flags2", 64'(out_flags), 64'h8);
    step();

    // Overflow set beats a same-cycle clear
    set_in(1'b1, 32'hC, 4'b1000, 4'd3, 1'b1);
    clr_sticky = 1'b1;
    step();
    chk("sticky_set_wins", 64'(sticky_ovf), 64'd1);
    chk("flags_ovf", 64'(flags_q), 64'h8);
    set_in(1'b0, '0, '0, '0, 1'b0);
    step();
    chk("sticky_clr", 64'(sticky_ovf), 64'd0);
    clr_sticky = 1'b0;

    // Reset with three entries buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'(20 + i), 4'b0100, TAG_W'(i), 1'b1);
      step();
    end
    chk("mid_count", 64'(count), 64'd3);
    chk("mid_flags", 64'(flags_q), 64'h4);
    set_in(1'b0, '0, '0, '0, 1'b0);
    rst = 1'b1;
    step();
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_flags", 64'(flags_q), 64'd0);
    set_in(1'b1, 32'hDEADBEEF, 4'b0010, 4'd9, 1'b0);
    step();
    set_in(1'b0, '0, '0, '0, 1'b0);
    chk("dead_valid", 64'(out_valid), 64'd1);
    chk("dead_y", 64'(out_y), 64'hDEADBEEF);
    chk("dead_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_buf.md
# alu_result_buf

Registered result stage directly downstream of the combinational ALU. Accepts each ALU result (y, O/C/Z/N flags, caller tag) through a valid/ready handshake and buffers it in a DEPTH-entry FIFO. Presents buffered results in order to the writeback consumer. Maintains the architectural flag register and a sticky overflow bit, which decouples the ALU's single-cycle combinational path from writeback backpressure.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- TAG_W, 4, width of the caller tag carried with each result

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  ALU result present
- in_ready  out  1  buffer can accept; = ~rst & (count < DEPTH)
- in_y  in  32  ALU result
- in_flags  in  4  {O,C,Z,N} from ALU
- in_tag  in  TAG_W  caller tag
- in_flag_we  in  1  this result updates flags_q / sticky_ovf
- out_valid  out  1  head entry valid; = (count != 0)
- out_ready  in  1  consumer takes head
- out_y  out  32  head result; 0 when out_valid=0
- out_flags  out  4  head {O,C,Z,N}; 0 when out_valid=0
- out_tag  out  TAG_W  head tag; 0 when out_valid=0
- flags_q  out  4  architectural {O,C,Z,N}
- sticky_ovf  out  1  set by any accepted flag-writing result with O=1
- clr_sticky  in  1  clears sticky_ovf
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Push: in_valid & in_ready at an edge. The entry {in_y, in_flags, in_tag} is written at wr_ptr, and wr_ptr increments mod DEPTH.
- Pop: out_valid & out_ready at an edge. rd_ptr increments mod DEPTH.
- Simultaneous push and pop: both happen and count is unchanged. This is legal at any non-full, non-empty occupancy. At full, in_ready=0, so no push occurs. At empty, out_valid=0, so no pop occurs.
- in_valid while in_ready=0: ignored. The upstream holder keeps its operands stable; this block stores nothing.
- out_ready while out_valid=0: ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are decided from count, not from pointer compare.
- flags_q: loaded with in_flags on a push with in_flag_we=1. Otherwise it holds. It updates at the push edge, independent of when that entry is popped.
- sticky_ovf:
  - set on a push with in_flag_we=1 and in_flags[O]=1;
  - cleared by clr_sticky;
  - if both occur in one cycle, set wins.
- Flags are stored exactly as received. No recomputation or masking is done here.
- Reset (rst=1 at an edge) clears: pointers, count, flags_q, sticky_ovf.
  - While rst is high, in_ready=0 and out_valid=0.
  - Reset mid-stream discards all buffered entries. Memory contents need not be cleared.

## Timing
- Push-to-out latency: 1 cycle. An entry pushed at edge k is visible on out_* after edge k, when it is the head.
- Throughput: 1 push and 1 pop per cycle sustained.
- in_ready depends only on registered count and rst. It has no combinational path from out_ready.
- out_* are read combinationally from the storage array at rd_ptr and gated by out_valid. There is no input-to-output combinational path.
- flags_q and sticky_ovf reflect a push one cycle after its edge, i.e. the register output after edge k.

## Structure
- alu_pkg holds:
  - typedef alu_flags_t, a packed struct {O,C,Z,N};
  - flag index constants FLAG_O=3, FLAG_C=2, FLAG_Z=1, FLAG_N=0;
  - opcode enum (ADD=0, SUB=1, INC=2, AND=3, OR=4, XOR=5, NOT=6) for benches and neighbours.
- One sub-module: sync_fifo, a generic parameterised width/depth FIFO with count. The flag register and sticky logic stay in alu_result_buf.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1. Required: in_ready=0, out_valid=0, count=0, flags_q=0, sticky_ovf=0 throughout; no entry accepted.
- Fill and drain, DEPTH=4, out_ready=0: push y=1,2,3,4 (tags 0..3). Required: count=4, in_ready=0, a 5th push ignored. Then set out_ready=1. Required: out_y=1,2,3,4 on consecutive cycles, then out_valid=0.
- Simultaneous push/pop at count=2 for 6 cycles. Required: count stays 2, order preserved, pointers wrap past 3→0 with no loss.
- Flags: push flags=4'b0001 with in_flag_we=1, then flags=4'b1000 with in_flag_we=0. Required: flags_q=0001 after the first edge and still 0001 after the second; the second entry's out_flags=1000.
- Sticky: push O=1 with in_flag_we=1 in the same cycle as clr_sticky=1. Required: sticky_ovf=1. Then clr_sticky alone. Required: sticky_ovf=0.
- Reset mid-stream: count=3, assert rst for one edge. Required: count=0, out_valid=0; next push of y=0xDEADBEEF appears at the head.
